// File: rtl/sfp_tx_ctrl.sv
// rtl/sfp_tx_ctrl.sv - per-port SFP TX_DISABLE control with insertion settle window
//
// Eight identical port FSMs. A newly inserted module is held laser-off for
// SETTLE_TICKS ticks of clk_100hz before the host disable register is honoured.
// Optional automatic laser shutdown (ALS) is built when SFP_ALS_EN is defined.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   clk_100hz      100 Hz single-cycle tick strobe (clk domain)
//   sfp_only_reg   filtered MOD_ABS per port, 1 = module absent
//   sfp_los_reg    filtered LOS per port, 1 = loss of signal (ALS build only)
//   sfp_txdis_reg  host TX disable per port, 1 = disable
//   sfp_txdis_pin  TX_DISABLE pad drive, 1 = laser off
//   sfp_tx_rdy     1 = port running with host enable active
//   sfp_als_act    1 = port in an ALS state (tied 0 without SFP_ALS_EN)
module sfp_tx_ctrl #(
  parameter int SETTLE_TICKS    = 50,
  parameter int ALS_OFF_TICKS   = 200,
  parameter int ALS_PROBE_TICKS = 2,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_100hz,
  input  logic [7:0] sfp_only_reg,
  input  logic [7:0] sfp_los_reg,
  input  logic [7:0] sfp_txdis_reg,
  output logic [7:0] sfp_txdis_pin,
  output logic [7:0] sfp_tx_rdy,
  output logic [7:0] sfp_als_act
);

  typedef enum logic [2:0] {
    ST_ABSENT,
    ST_SETTLE,
    ST_RUN
`ifdef SFP_ALS_EN
    ,
    ST_ALS_OFF,
    ST_ALS_PROBE
`endif
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

`ifdef SFP_ALS_EN
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(ALS_OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] PROBE_LAST = CNT_W'(ALS_PROBE_TICKS - 1);
`else
  // LOS and the ALS timing parameters have no function in this build.
  logic unused_als;
  assign unused_als = ^{sfp_los_reg, CNT_W'(ALS_OFF_TICKS), CNT_W'(ALS_PROBE_TICKS)};
  assign sfp_als_act = 8'h00;
`endif

  for (genvar i = 0; i < 8; i++) begin : g_port
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pin_q, pin_nxt;
    logic             rdy_q, rdy_nxt;
    logic             absent, los, txdis;

    assign absent = sfp_only_reg[i];
    assign los    = sfp_los_reg[i];
    assign txdis  = sfp_txdis_reg[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_ABSENT;
        cnt   <= '0;
        pin_q <= 1'b1;
        rdy_q <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        pin_q <= pin_nxt;
        rdy_q <= rdy_nxt;
      end
    end

`ifdef SFP_ALS_EN
    logic als_q, als_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) als_q <= 1'b0;
      else        als_q <= als_nxt;
    end

    assign sfp_als_act[i] = als_q;
`endif

    // Outputs are decoded from the current state and inputs, then registered,
    // so every change reaches the pads one clk later.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pin_nxt   = 1'b1;
      rdy_nxt   = 1'b0;
`ifdef SFP_ALS_EN
      als_nxt   = 1'b0;
`endif
      case (state)
        ST_ABSENT: begin
          cnt_nxt = '0;
          if (!absent) state_nxt = ST_SETTLE;
        end
        ST_SETTLE: begin
          // Removal outranks a terminal tick in the same clk.
          if (absent) begin
            state_nxt = ST_ABSENT;
            cnt_nxt   = '0;
          end else if (clk_100hz) begin
            if (cnt == SETTLE_LAST) begin
              state_nxt = ST_RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        ST_RUN: begin
          pin_nxt = txdis;
          rdy_nxt = ~txdis;
          if (absent) begin
            state_nxt = ST_ABSENT;
            cnt_nxt   = '0;
          end
`ifdef SFP_ALS_EN
          else if (!txdis && los) begin
            state_nxt = ST_ALS_OFF;
            cnt_nxt   = '0;
          end
`endif
        end
`ifdef SFP_ALS_EN
        ST_ALS_OFF: begin
          als_nxt = 1'b1;
          if (absent) begin
            state_nxt = ST_ABSENT;
            cnt_nxt   = '0;
          end else if (txdis) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else if (clk_100hz) begin
            if (cnt == OFF_LAST) begin
              state_nxt = ST_ALS_PROBE;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
        ST_ALS_PROBE: begin
          pin_nxt = 1'b0;
          als_nxt = 1'b1;
          // Light returning during the probe ends ALS before any tick.
          if (absent) begin
            state_nxt = ST_ABSENT;
            cnt_nxt   = '0;
          end else if (txdis || !los) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else if (clk_100hz) begin
            if (cnt == PROBE_LAST) begin
              state_nxt = ST_ALS_OFF;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end
        end
`endif
        default: begin
          state_nxt = ST_ABSENT;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign sfp_txdis_pin[i] = pin_q;
    assign sfp_tx_rdy[i]    = rdy_q;
  end

endmodule
